led_breath: RTL
===============

# led_breath

Downstream LED stage for the Tang Nano 20K board. It consumes the single-cycle step strobe produced by the board's tick divider and drives one LED pad with a "breathing" fade: up, hold, down, hold. Brightness comes from a free-running PWM whose duty is stepped once per strobe by a five-state sequencer. The 27 MHz board clock is used directly; the strobe sets the fade speed.

## Interface
Parameters:
- PWM_BITS, 8: PWM resolution; brightness range 0..2^PWM_BITS-1 (MAX).
- STEP, 1: brightness change per accepted tick; legal 1..MAX.
- HOLD_TICKS, 4: ticks spent at peak and at floor; legal 1..255.

Ports:
- clk  in  1  board clock, 27 MHz; one clock domain, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  single-cycle step strobe from the upstream divider.
- en  in  1  level-sensitive run enable.
- led  out  1  LED drive, registered; 1 = lit.
- level  out  PWM_BITS  current brightness.
- at_peak  out  1  high while in HOLD_HI.
- cycle_done  out  1  one-cycle pulse at each HOLD_LO→RISE transition.

## Operation
- States: IDLE, RISE, HOLD_HI, FALL, HOLD_LO.
- IDLE: level=0, hold_cnt=0. On a cycle with en=1, go to RISE. Ticks are ignored in IDLE, including one coincident with the en rise.
- In any non-IDLE state, en=0 forces IDLE and level=0 on the next edge. This takes priority over tick.
- RISE, on tick: sum = level+STEP, computed PWM_BITS+1 wide.
  - If sum ≥ MAX: level=MAX, go to HOLD_HI, hold_cnt=0.
  - Otherwise: level=sum.
- HOLD_HI, on tick:
  - If hold_cnt==HOLD_TICKS-1: go to FALL, hold_cnt=0.
  - Otherwise: hold_cnt+1.
- FALL, on tick:
  - If level ≤ STEP: level=0, go to HOLD_LO, hold_cnt=0.
  - Otherwise: level-STEP.
- HOLD_LO: same hold rule as HOLD_HI, but exits to RISE and asserts cycle_done.
- No wrap-around of level in either direction. It saturates at 0 and MAX.
- PWM:
  - pwm_cnt is free-running 0..MAX and wraps to 0. It runs in every state, including IDLE.
  - duty is latched from the brightness mapping only on the cycle pwm_cnt==MAX. This keeps pulses glitch-free.
  - led <= (pwm_cnt < duty).
  - duty=0 gives never lit. duty=MAX gives lit MAX of 2^PWM_BITS cycles.

## Timing
- Reset values: led=0, level=0, at_peak=0, cycle_done=0, state=IDLE, pwm_cnt=0, duty=0, hold_cnt=0.
- rst mid-operation returns every register to these values on the next edge; in-flight fades are discarded.
- level, at_peak and cycle_done are registered. They update on the edge that samples the tick, so they are visible the cycle after tick=1.
- A new level reaches duty at the next pwm_cnt==MAX edge. Worst case is 2^PWM_BITS cycles.
- led lags the pwm_cnt/duty compare by 1 cycle.
- Back-to-back ticks on consecutive cycles are each accepted. No minimum tick spacing applies.
- cycle_done is exactly one cycle wide and never asserts outside the HOLD_LO→RISE edge.

## Configuration
- LED_BREATH_GAMMA_EN defined:
  - duty = (level*level) >> PWM_BITS, using a 2·PWM_BITS-wide product truncated to PWM_BITS.
  - For level=MAX, duty is forced to MAX so the peak stays full-scale.
- Undefined: duty = level (linear).
- FSM, level and all ports are identical in both builds. Only the duty mapping differs.

## Structure
- Package led_pkg:
  - Typedef for the state enum (IDLE, RISE, HOLD_HI, FALL, HOLD_LO).
  - Helper constant for MAX derived from PWM_BITS.
- Sub-module pwm_gen, parameterised by PWM_BITS. It owns pwm_cnt, duty latching at wrap, and the registered led compare.
- led_breath holds the sequencer, the hold counter and the brightness mapping.

## Test plan
Scenarios 1–4 run with PWM_BITS=4, STEP=4, HOLD_TICKS=2.
1. Reset then en=0, 50 ticks: level, led, at_peak and cycle_done stay 0.
2. en=1 and repeated ticks:
   - level sequence: 4, 8, 12, 15.
   - at_peak=1 after the 4th tick.
   - Two ticks later FALL gives 11, 7, 3, 0.
   - Two ticks later, cycle_done pulses once and level steps to 4 on the next tick.
3. Force level=15 (linear build): exactly 15 of every 16 cycles have led=1. At level=0, no cycle has led=1.
4. Tick issued mid-PWM-period, level changes 4→8: led high time stays 4 cycles until the first period after pwm_cnt wraps, then becomes 8 cycles.
5. Abort and reset during a fade:
   - en dropped during FALL at level=7: level=0 and IDLE next cycle.
   - rst asserted together with tick in HOLD_HI: all outputs return to reset values and the tick is ignored.
6. LED_BREATH_GAMMA_EN with PWM_BITS=8: level=128 gives duty=64, level=255 gives duty=255, level=15 gives duty=0.

Source files
------------

// File: rtl/led_pkg.sv
// ----------------------------------------------------------------------------
// led_pkg
// Shared types and helpers for the LED breathing stage.
//   state_e    : sequencer states (IDLE, RISE, HOLD_HI, FALL, HOLD_LO)
//   max_level(): full-scale brightness for a given PWM resolution
// Optional build macro used by led_breath: LED_BREATH_GAMMA_EN
// ----------------------------------------------------------------------------
package led_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RISE    = 3'd1,
        HOLD_HI = 3'd2,
        FALL    = 3'd3,
        HOLD_LO = 3'd4
    } state_e;

    // Full-scale brightness (2^bits - 1).
    function automatic int unsigned max_level(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

endpackage

// File: rtl/led_breath_pwm_gen.sv
// ----------------------------------------------------------------------------
// pwm_gen
// Free-running PWM with glitch-free duty update.
//   clk     in  board clock
//   rst     in  synchronous active-high reset
//   duty_i  in  requested duty (0..MAX); sampled only when the counter is MAX
//   led_o   out registered PWM output, 1 = lit
// The counter runs 0..MAX and wraps naturally at PWM_BITS width. Latching
// duty only on the last count of a period means a period never mixes two
// duty values, so pulse widths are always whole.
// ----------------------------------------------------------------------------
module pwm_gen #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] duty_i,
    output logic                led_o
);

    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                led_q, led_d;

    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        duty_d = duty_q;
        if (cnt_q == CNT_MAX) begin
            duty_d = duty_i;
        end
        // Compare uses the duty in force for this period; the new duty only
        // applies from the next count 0.
        led_d = (cnt_q < duty_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            duty_q <= '0;
            led_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
            led_q  <= led_d;
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/led_breath.sv
// ----------------------------------------------------------------------------
// led_breath
// Breathing LED driver: brightness ramps up, holds, ramps down, holds, and
// repeats, advancing one step per tick strobe while enabled.
//   clk         in  board clock (27 MHz), single domain
//   rst         in  synchronous active-high reset
//   tick        in  single-cycle step strobe
//   en          in  level-sensitive run enable
//   led         out registered LED drive, 1 = lit
//   level       out current brightness 0..MAX
//   at_peak     out high while holding at full brightness
//   cycle_done  out one-cycle pulse when the low hold ends and a new rise starts
// Build option: define LED_BREATH_GAMMA_EN to map brightness to duty through
// a square-law curve; otherwise duty equals level.
// ----------------------------------------------------------------------------
module led_breath
    import led_pkg::*;
#(
    parameter int PWM_BITS   = 8,
    parameter int STEP       = 1,
    parameter int HOLD_TICKS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                en,
    output logic                led,
    output logic [PWM_BITS-1:0] level,
    output logic                at_peak,
    output logic                cycle_done
);

    localparam int unsigned         MAX_U     = max_level(PWM_BITS);
    localparam logic [PWM_BITS-1:0] MAX_L     = PWM_BITS'(MAX_U);
    localparam logic [PWM_BITS-1:0] STEP_L    = PWM_BITS'(STEP);
    localparam logic [7:0]          HOLD_LAST = 8'(HOLD_TICKS - 1);

    state_e              state_q, state_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic [7:0]          hold_q, hold_d;
    logic                at_peak_q, at_peak_d;
    logic                done_q, done_d;

    // One extra bit so level+STEP cannot wrap before the saturation test.
    logic [PWM_BITS:0]   sum;
    assign sum = {1'b0, level_q} + {1'b0, STEP_L};

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        hold_d  = hold_q;
        done_d  = 1'b0;

        if (state_q != IDLE && !en) begin
            // Dropping enable aborts the fade, even on a tick cycle.
            state_d = IDLE;
            level_d = '0;
            hold_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    level_d = '0;
                    hold_d  = '0;
                    if (en) begin
                        state_d = RISE;
                    end
                end
                RISE: begin
                    if (tick) begin
                        if (sum >= {1'b0, MAX_L}) begin
                            level_d = MAX_L;
                            state_d = HOLD_HI;
                            hold_d  = '0;
                        end else begin
                            level_d = sum[PWM_BITS-1:0];
                        end
                    end
                end
                HOLD_HI: begin
                    if (tick) begin
                        if (hold_q == HOLD_LAST) begin
                            state_d = FALL;
                            hold_d  = '0;
                        end else begin
                            hold_d = hold_q + 8'd1;
                        end
                    end
                end
                FALL: begin
                    if (tick) begin
                        if (level_q <= STEP_L) begin
                            level_d = '0;
                            state_d = HOLD_LO;
                            hold_d  = '0;
                        end else begin
                            level_d = level_q - STEP_L;
                        end
                    end
                end
                HOLD_LO: begin
                    if (tick) begin
                        if (hold_q == HOLD_LAST) begin
                            state_d = RISE;
                            hold_d  = '0;
                            done_d  = 1'b1;
                        end else begin
                            hold_d = hold_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    level_d = '0;
                    hold_d  = '0;
                end
            endcase
        end

        at_peak_d = (state_d == HOLD_HI);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            level_q   <= '0;
            hold_q    <= '0;
            at_peak_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            hold_q    <= hold_d;
            at_peak_q <= at_peak_d;
            done_q    <= done_d;
        end
    end

    // Brightness to duty mapping.
    logic [PWM_BITS-1:0] duty;
`ifdef LED_BREATH_GAMMA_EN
    logic [2*PWM_BITS-1:0] level_w;
    logic [2*PWM_BITS-1:0] level_sq;
    assign level_w  = {{PWM_BITS{1'b0}}, level_q};
    assign level_sq = level_w * level_w;
    // Square law alone tops out just below full scale; pin the peak to MAX.
    assign duty = (level_q == MAX_L) ? MAX_L : level_sq[2*PWM_BITS-1:PWM_BITS];
`else
    assign duty = level_q;
`endif

    pwm_gen #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .clk    (clk),
        .rst    (rst),
        .duty_i (duty),
        .led_o  (led)
    );

    assign level      = level_q;
    assign at_peak    = at_peak_q;
    assign cycle_done = done_q;

endmodule
